// File: rtl/stopwatch_up_pkg.sv
// Shared stopwatch/timer definitions: BCD digit type, FSM state encoding,
// per-digit limits and the load clamp helper.
package stopwatch_up_pkg;

    localparam int unsigned DIGIT_W = 4;

    typedef logic [DIGIT_W-1:0] bcd_t;

    localparam bcd_t MAX_ONES     = 4'd9;
    localparam bcd_t MAX_SEC_TENS = 4'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_FULL  = 2'd3
    } sw_state_e;

    function automatic bcd_t clamp_digit(input bcd_t d, input bcd_t max_v);
        return (d > max_v) ? max_v : d;
    endfunction

endpackage

// File: rtl/bcd_up_digit.sv
// One BCD up-counting digit, modulo MODULUS, with parallel load.
// carry is combinational so a whole chain resolves in a single cycle.
module bcd_up_digit
    import stopwatch_up_pkg::*;
#(
    parameter int unsigned MODULUS = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic load,
    input  bcd_t d,
    output bcd_t q,
    output logic carry
);

    localparam bcd_t LAST = bcd_t'(MODULUS - 1);

    bcd_t q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = d;
        end else if (en) begin
            q_d = (q_q == LAST) ? '0 : q_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q     = q_q;
    assign carry = en && (q_q == LAST);

endmodule

// File: rtl/stopwatch_up.sv
// MM:SS up-counting stopwatch with run/pause FSM, clear, clamped load and
// saturate-or-wrap at 59:59. Optional lap freeze under `STOPWATCH_LAP_EN.
module stopwatch_up
    import stopwatch_up_pkg::*;
#(
    parameter int unsigned SATURATE = 1,
    parameter int unsigned TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        start_stop,
    input  logic        clear,
    input  logic        load,
    input  logic [15:0] load_val,
`ifdef STOPWATCH_LAP_EN
    input  logic        lap,
    output logic        lap_hold,
`endif
    output logic [15:0] digits,
    output logic        running,
    output logic        full,
    output logic        wrap_p,
    output logic        rco_L
);

    localparam logic [3:0] DIV_LAST = 4'(TICK_DIV - 1);

    sw_state_e  state_q, state_d;
    logic [3:0] div_q, div_d;
    logic       wrap_q, wrap_d;

    bcd_t       q0, q1, q2, q3;
    logic       c0, c1, c2, c3;
    logic [15:0] count;
    logic [15:0] load_bcd;
    logic       dig_load;
    logic       at_max, run_tick, div_hit, sat_stop, adv;

    assign count = {q3, q2, q1, q0};
    assign at_max = (count == 16'h5959);

    // Higher-priority controls in the same cycle suppress the tick entirely.
    assign run_tick = (state_q == ST_RUN) && !clear && !load && !start_stop && tick;
    assign div_hit  = run_tick && (div_q == DIV_LAST);
    assign sat_stop = div_hit && at_max && (SATURATE != 0);
    assign adv      = div_hit && !sat_stop;

    assign dig_load = clear || load;
    assign load_bcd = clear ? '0 :
                      {clamp_digit(load_val[15:12], MAX_SEC_TENS),
                       clamp_digit(load_val[11:8],  MAX_ONES),
                       clamp_digit(load_val[7:4],   MAX_SEC_TENS),
                       clamp_digit(load_val[3:0],   MAX_ONES)};

    bcd_up_digit #(.MODULUS(10)) u_sec_ones (
        .clk(clk), .rst(rst), .en(adv), .load(dig_load), .d(load_bcd[3:0]),   .q(q0), .carry(c0));
    bcd_up_digit #(.MODULUS(6))  u_sec_tens (
        .clk(clk), .rst(rst), .en(c0),  .load(dig_load), .d(load_bcd[7:4]),   .q(q1), .carry(c1));
    bcd_up_digit #(.MODULUS(10)) u_min_ones (
        .clk(clk), .rst(rst), .en(c1),  .load(dig_load), .d(load_bcd[11:8]),  .q(q2), .carry(c2));
    bcd_up_digit #(.MODULUS(6))  u_min_tens (
        .clk(clk), .rst(rst), .en(c2),  .load(dig_load), .d(load_bcd[15:12]), .q(q3), .carry(c3));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            wrap_q  <= wrap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ST_IDLE;
        end else if (load) begin
            state_d = ST_PAUSE;
        end else if (start_stop) begin
            case (state_q)
                ST_IDLE:  state_d = ST_RUN;
                ST_RUN:   state_d = ST_PAUSE;
                ST_PAUSE: state_d = ST_RUN;
                default:  state_d = state_q;
            endcase
        end else if (sat_stop) begin
            state_d = ST_FULL;
        end
    end

    // Carry out of min_tens only occurs on the 59:59 -> 00:00 roll-over.
    always_comb begin
        div_d = div_q;
        if (clear || load) begin
            div_d = '0;
        end else if (run_tick) begin
            div_d = div_hit ? '0 : div_q + 4'd1;
        end
        wrap_d = (SATURATE == 0) && c3;
    end

`ifdef STOPWATCH_LAP_EN
    logic        lap_hold_q, lap_hold_d;
    logic [15:0] lap_val_q, lap_val_d;

    always_comb begin
        lap_hold_d = lap_hold_q;
        lap_val_d  = lap_val_q;
        if (clear || load) begin
            lap_hold_d = 1'b0;
        end else if (lap && (state_q == ST_RUN)) begin
            lap_hold_d = !lap_hold_q;
            if (!lap_hold_q) begin
                lap_val_d = count;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            lap_hold_q <= 1'b0;
            lap_val_q  <= '0;
        end else begin
            lap_hold_q <= lap_hold_d;
            lap_val_q  <= lap_val_d;
        end
    end
`endif

    always_comb begin
`ifdef STOPWATCH_LAP_EN
        lap_hold = lap_hold_q;
        digits   = lap_hold_q ? lap_val_q : count;
`else
        digits   = count;
`endif
        running = (state_q == ST_RUN);
        full    = (state_q == ST_FULL);
        wrap_p  = wrap_q;
        rco_L   = !(at_max && (state_q == ST_RUN));
    end

endmodule

// File: tb/tb_stopwatch_up.sv
// Stopwatch bench: three configurations driven in lock-step and compared every
// cycle against a seconds-count model, plus literal scenario checks.
module tb_stopwatch_up;

    logic        clk = 1'b0;
    logic        rst, tick, start_stop, clear, load;
    logic [15:0] load_val;

    logic [15:0] dig [3];
    logic        run_o [3];
    logic        full_o [3];
    logic        wrap_o [3];
    logic        rco_o [3];

    always #5 clk = ~clk;

    stopwatch_up #(.SATURATE(1), .TICK_DIV(1)) dut_s (
        .clk(clk), .rst(rst), .tick(tick), .start_stop(start_stop), .clear(clear),
        .load(load), .load_val(load_val), .digits(dig[0]), .running(run_o[0]),
        .full(full_o[0]), .wrap_p(wrap_o[0]), .rco_L(rco_o[0]));

    stopwatch_up #(.SATURATE(0), .TICK_DIV(1)) dut_w (
        .clk(clk), .rst(rst), .tick(tick), .start_stop(start_stop), .clear(clear),
        .load(load), .load_val(load_val), .digits(dig[1]), .running(run_o[1]),
        .full(full_o[1]), .wrap_p(wrap_o[1]), .rco_L(rco_o[1]));

    stopwatch_up #(.SATURATE(0), .TICK_DIV(3)) dut_d (
        .clk(clk), .rst(rst), .tick(tick), .start_stop(start_stop), .clear(clear),
        .load(load), .load_val(load_val), .digits(dig[2]), .running(run_o[2]),
        .full(full_o[2]), .wrap_p(wrap_o[2]), .rco_L(rco_o[2]));

    int nvec  = 0;
    int nfail = 0;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        nvec++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: elapsed seconds as a plain integer, mode as a small label.
    typedef enum {M_IDLE, M_RUN, M_PAUSE, M_FULL} mode_t;
    int unsigned secs [3];
    mode_t       mode [3];
    int unsigned tcnt [3];
    bit          wrapm [3];
    int unsigned satp [3] = '{1, 0, 0};
    int unsigned divp [3] = '{1, 1, 3};

    function automatic logic [15:0] to_bcd(input int unsigned s);
        int unsigned m, sec;
        m   = s / 60;
        sec = s % 60;
        return {4'(m / 10), 4'(m % 10), 4'(sec / 10), 4'(sec % 10)};
    endfunction

    function automatic int unsigned load_secs(input logic [15:0] v);
        int unsigned mt, mo, st, so;
        mt = (v[15:12] > 5) ? 5 : int'(v[15:12]);
        mo = (v[11:8]  > 9) ? 9 : int'(v[11:8]);
        st = (v[7:4]   > 5) ? 5 : int'(v[7:4]);
        so = (v[3:0]   > 9) ? 9 : int'(v[3:0]);
        return (mt * 10 + mo) * 60 + st * 10 + so;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            int unsigned s, t;
            mode_t       m;
            bit          w;
            s = secs[i]; t = tcnt[i]; m = mode[i]; w = 1'b0;
            if (!rst || clear) begin
                s = 0; t = 0; m = M_IDLE;
            end else if (load) begin
                s = load_secs(load_val); t = 0; m = M_PAUSE;
            end else if (start_stop) begin
                if (m == M_IDLE || m == M_PAUSE) m = M_RUN;
                else if (m == M_RUN) m = M_PAUSE;
            end else if (tick && m == M_RUN) begin
                t++;
                if (t == divp[i]) begin
                    t = 0;
                    if (s == 3599) begin
                        if (satp[i] != 0) m = M_FULL;
                        else begin s = 0; w = 1'b1; end
                    end else begin
                        s++;
                    end
                end
            end
            secs[i] <= s; tcnt[i] <= t; mode[i] <= m; wrapm[i] <= w;
        end
    end

    bit chk_en = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("digits[%0d]", i),  dig[i],          to_bcd(secs[i]));
                check($sformatf("running[%0d]", i), 16'(run_o[i]),   16'(mode[i] == M_RUN));
                check($sformatf("full[%0d]", i),    16'(full_o[i]),  16'(mode[i] == M_FULL));
                check($sformatf("wrap_p[%0d]", i),  16'(wrap_o[i]),  16'(wrapm[i]));
                check($sformatf("rco_L[%0d]", i),   16'(rco_o[i]),
                      16'(!(secs[i] == 3599 && mode[i] == M_RUN)));
            end
        end
    end

    // Drive one edge's inputs, return at the following negedge with idle inputs.
    task automatic drive(input bit r, input bit cl, input bit ld, input logic [15:0] lv,
                         input bit ss, input bit tk);
        rst = r; clear = cl; load = ld; load_val = lv; start_stop = ss; tick = tk;
        @(negedge clk);
        rst = 1'b1; clear = 1'b0; load = 1'b0; start_stop = 1'b0; tick = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            secs[i] = 0; tcnt[i] = 0; mode[i] = M_IDLE; wrapm[i] = 1'b0;
        end
        rst = 1'b0; clear = 1'b0; load = 1'b0; load_val = '0; start_stop = 1'b0; tick = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        drive(0, 0, 0, 16'h0, 0, 0);
        check("reset_digits", dig[0], 16'h0000);
        check("reset_rco", 16'(rco_o[0]), 16'h1);

        // Reset while running at 12:34
        drive(1, 0, 1, 16'h1234, 0, 0);
        drive(1, 0, 0, 16'h0, 1, 0);
        check("run_1234", dig[0], 16'h1234);
        check("run_running", 16'(run_o[0]), 16'h1);
        drive(0, 0, 0, 16'h0, 0, 0);
        check("rst_digits", dig[0], 16'h0000);
        check("rst_running", 16'(run_o[0]), 16'h0);
        check("rst_rco", 16'(rco_o[0]), 16'h1);

        // Full carry chain in one tick
        drive(1, 0, 1, 16'h0959, 0, 0);
        drive(1, 0, 0, 16'h0, 1, 0);
        drive(1, 0, 0, 16'h0, 0, 1);
        check("carry_1000", dig[0], 16'h1000);

        // Saturate on dut_s, wrap on dut_w
        drive(1, 0, 1, 16'h5958, 0, 0);
        drive(1, 0, 0, 16'h0, 1, 0);
        drive(1, 0, 0, 16'h0, 0, 1);
        check("sat_5959", dig[0], 16'h5959);
        check("sat_rco_low", 16'(rco_o[0]), 16'h0);
        check("wrap_rco_low", 16'(rco_o[1]), 16'h0);
        drive(1, 0, 0, 16'h0, 0, 1);
        check("sat_hold", dig[0], 16'h5959);
        check("sat_full", 16'(full_o[0]), 16'h1);
        check("wrap_0000", dig[1], 16'h0000);
        check("wrap_pulse", 16'(wrap_o[1]), 16'h1);
        drive(1, 0, 0, 16'h0, 0, 1);
        check("sat_hold2", dig[0], 16'h5959);
        check("wrap_pulse_end", 16'(wrap_o[1]), 16'h0);
        drive(1, 0, 0, 16'h0, 1, 0);
        check("full_ignores_ss", 16'(full_o[0]), 16'h1);
        check("full_not_running", 16'(run_o[0]), 16'h0);

        // start_stop and tick together while running
        drive(1, 1, 0, 16'h0, 0, 0);
        drive(1, 0, 1, 16'h0005, 0, 0);
        drive(1, 0, 0, 16'h0, 1, 0);
        drive(1, 0, 0, 16'h0, 1, 1);
        check("simul_paused", 16'(run_o[0]), 16'h0);
        check("simul_digits", dig[0], 16'h0005);
        drive(1, 0, 1, 16'h7FAA, 0, 0);
        check("clamp_5959", dig[0], 16'h5959);

        for (int n = 0; n < 4000; n++) begin
            logic [15:0] lv;
            lv = ($urandom_range(0, 1) == 1) ? 16'($urandom)
                                             : {12'h595, 4'($urandom_range(0, 9))};
            drive($urandom_range(0, 299) != 0, $urandom_range(0, 79) == 0,
                  $urandom_range(0, 39) == 0, lv, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 2) != 0);
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
